// File: rtl/mbyte_arith_seq.sv
// Multi-byte add/subtract sequencer: feeds an external 8-bit adder LSB first and chains the carry.
// Optional build macro MBSEQ_CARRY_IN_EN adds ext_cin to seed the carry chain (ADC/SBC chaining).
module mbyte_arith_seq #(
  parameter int LEN_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub_in,
  input  logic [LEN_W-1:0] len,
`ifdef MBSEQ_CARRY_IN_EN
  input  logic             ext_cin,
`endif
  input  logic             in_valid,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             in_ready,
  output logic [7:0]       as_a,
  output logic [7:0]       as_b,
  output logic             as_cin,
  output logic             as_sub,
  output logic             as_take_carry,
  input  logic [7:0]       as_sum,
  input  logic             as_cout,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               sub_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   idx;
  logic               carry_r;
  logic               zacc;
  logic               seed;
  logic               in_accept;
  logic               out_accept;
  logic               last_byte;

`ifdef MBSEQ_CARRY_IN_EN
  assign seed = ext_cin;
`else
  assign seed = sub_in;
`endif

  // Subtraction is done here (invert b, carry seeded to 1) so the adder's own sub mode stays off
  assign as_a          = in_a;
  assign as_b          = sub_r ? ~in_b : in_b;
  assign as_cin        = carry_r;
  assign as_sub        = 1'b0;
  assign as_take_carry = 1'b1;

  assign out_accept = out_valid & out_ready;
  assign in_ready   = (state == RUN) & (~out_valid | out_ready);
  assign in_accept  = in_valid & in_ready;
  assign last_byte  = (idx == len_r);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (in_accept && last_byte) state_next = FLUSH;
      FLUSH:   if (out_accept && out_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sub_r      <= 1'b0;
      len_r      <= '0;
      idx        <= '0;
      carry_r    <= 1'b0;
      zacc       <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b1;
    end else begin
      if (state == IDLE && start) begin
        sub_r   <= sub_in;
        len_r   <= len;
        carry_r <= seed;
        idx     <= '0;
        zacc    <= 1'b1;
      end
      // Single-entry output buffer: a new byte may replace the one leaving in the same cycle
      if (in_accept) begin
        out_data  <= as_sum;
        out_valid <= 1'b1;
        out_last  <= last_byte;
        carry_r   <= as_cout;
        zacc      <= zacc & (as_sum == 8'h00);
        idx       <= idx + 1'b1;
      end else if (out_accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (out_accept && out_last) begin
        carry_flag <= carry_r;
        zero_flag  <= zacc;
      end
    end
  end

endmodule

// File: tb/tb_mbyte_arith_seq.sv
// Directed bench for mbyte_arith_seq with a behavioural 8-bit adder closing the loop.
module tb_mbyte_arith_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       sub_in;
  logic [1:0] len;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_ready;
  logic [7:0] as_a;
  logic [7:0] as_b;
  logic       as_cin;
  logic       as_sub;
  logic       as_take_carry;
  logic [7:0] as_sum;
  logic       as_cout;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       carry_flag;
  logic       zero_flag;

  int check_count = 0;
  int pass_count  = 0;
  int done_cnt    = 0;
  logic [7:0] got_q[$];
  logic       last_q[$];

  always #5 clock = ~clock;

  mbyte_arith_seq #(.LEN_W(2)) dut (
    .clock(clock), .reset(reset), .start(start), .sub_in(sub_in), .len(len),
`ifdef MBSEQ_CARRY_IN_EN
    .ext_cin(sub_in),
`endif
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .as_a(as_a), .as_b(as_b), .as_cin(as_cin), .as_sub(as_sub),
    .as_take_carry(as_take_carry), .as_sum(as_sum), .as_cout(as_cout),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  // Plain 8-bit adder with carry in (sub mode never used by the sequencer)
  always_comb {as_cout, as_sum} = {1'b0, as_a} + {1'b0, as_b} + {8'h00, as_cin};

  always @(posedge clock) begin
    if (!reset && out_valid && out_ready) begin
      got_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] l);
    start  = 1'b1;
    sub_in = s;
    len    = l;
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && t < 40) begin
      @(negedge clock);
      #1;
      t++;
    end
    checkOutput("in_ready reached", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int t = 0;
    while (busy && t < 40) begin
      @(negedge clock);
      t++;
    end
    checkOutput({tag, " idle"}, busy, 0);
  endtask

  task automatic verifyOp(input string tag, input int n, input logic [31:0] exp_bytes,
                          input logic exp_c, input logic exp_z, input int d0);
    checkOutput({tag, " count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) begin
        checkOutput($sformatf("%s byte%0d", tag, i), got_q[i], exp_bytes[8*i +: 8]);
        checkOutput($sformatf("%s last%0d", tag, i), last_q[i], (i == n - 1));
      end
    end
    checkOutput({tag, " carry_flag"}, carry_flag, exp_c);
    checkOutput({tag, " zero_flag"}, zero_flag, exp_z);
    checkOutput({tag, " done pulses"}, done_cnt - d0, 1);
  endtask

  task automatic runOp(input string tag, input logic s, input logic [1:0] l,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_bytes,
                       input logic exp_c, input logic exp_z);
    int d0;
    got_q.delete();
    last_q.delete();
    d0 = done_cnt;
    applyStimulus(s, l);
    for (int i = 0; i <= int'(l); i++) sendByte(a[8*i +: 8], b[8*i +: 8]);
    waitIdle(tag);
    verifyOp(tag, int'(l) + 1, exp_bytes, exp_c, exp_z, d0);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; sub_in = 1'b0; len = 2'd0;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst busy", busy, 0);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst in_ready", in_ready, 0);
    checkOutput("rst carry_flag", carry_flag, 0);
    checkOutput("rst zero_flag", zero_flag, 1);
    checkOutput("rst as_cin", as_cin, 0);
    checkOutput("rst as_sub", as_sub, 0);
    checkOutput("rst as_take_carry", as_take_carry, 1);
    @(negedge clock);

    runOp("add16", 1'b0, 2'd1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
    runOp("sub16 nb", 1'b1, 2'd1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0);
    runOp("sub16 bw", 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0);
    runOp("add8 zero", 1'b0, 2'd0, 32'h0000_0080, 32'h0000_0080, 32'h0000_0000, 1'b1, 1'b1);

    // Backpressure: buffer full holds off input; start while busy is ignored
    got_q.delete();
    last_q.delete();
    d0 = done_cnt;
    out_ready = 1'b0;
    applyStimulus(1'b0, 2'd3);
    sendByte(8'h01, 8'hFF);
    in_valid = 1'b1; in_a = 8'h7F; in_b = 8'h80;
    for (int k = 0; k < 5; k++) begin
      start  = (k == 2);
      sub_in = 1'b1;
      #1;
      checkOutput("bp in_ready", in_ready, 0);
      checkOutput("bp out_valid", out_valid, 1);
      checkOutput("bp out_data", out_data, 8'h00);
      @(negedge clock);
    end
    start = 1'b0;
    out_ready = 1'b1;
    sendByte(8'h7F, 8'h80);
    sendByte(8'hFF, 8'h01);
    sendByte(8'h80, 8'h7F);
    waitIdle("bp");
    verifyOp("bp", 4, 32'h0001_0000, 1'b1, 1'b0, d0);

    // Reset mid-operation with carry_r set, then a fresh add must see carry 0
    d0 = done_cnt;
    applyStimulus(1'b1, 2'd3);
    sendByte(8'h00, 8'h00);
    sendByte(8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midrst busy", busy, 0);
    checkOutput("midrst out_valid", out_valid, 0);
    checkOutput("midrst in_ready", in_ready, 0);
    repeat (3) @(negedge clock);
    checkOutput("midrst no done", done_cnt - d0, 0);
    runOp("post rst add", 1'b0, 2'd1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
